// File: rtl/cpu_bus_serdes_if.sv
// CPU request/ack signals and narrow pad-lane signals of cpu_bus_serdes.
// slave = the serdes itself, master = core plus pad environment.
interface cpu_bus_serdes_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANE_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              busy;
    logic [LANE_W-1:0] bus_addr_o;
    logic [LANE_W-1:0] bus_data_o;
    logic [LANE_W-1:0] bus_data_i;
    logic [LANE_W-1:0] bus_data_oe;
    logic              bus_frame;
    logic              bus_ready_i;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_data_i, bus_ready_i,
        input  cpu_ack, cpu_rdata, busy, bus_addr_o, bus_data_o, bus_data_oe, bus_frame
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_data_i, bus_ready_i,
        output cpu_ack, cpu_rdata, busy, bus_addr_o, bus_data_o, bus_data_oe, bus_frame
    );
endinterface

// File: rtl/cpu_bus_serdes.sv
// Serialises one CPU transaction onto LANE_W-wide pad lanes (ADDR, CMD, DATA beats)
// and reassembles read data. Define BUS_WAIT_EN to advance beats only on bus_ready_i.
module cpu_bus_serdes #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANE_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    cpu_bus_serdes_if.slave bus
);
    localparam int unsigned A_BEATS   = ADDR_W / LANE_W;
    localparam int unsigned D_BEATS   = DATA_W / LANE_W;
    localparam int unsigned MAX_BEATS = (A_BEATS > D_BEATS) ? A_BEATS : D_BEATS;
    localparam int unsigned CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_BEATS - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_BEATS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, CMD, DATA, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  beat;
    logic              we_q;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] rd_next;
    logic [LANE_W-1:0] cmd_word;
    logic              advance;

`ifdef BUS_WAIT_EN
    assign advance = bus.bus_ready_i;
`else
    logic unused_ready;
    assign advance      = 1'b1;
    assign unused_ready = bus.bus_ready_i;
`endif

    // Latched address/write data are kept as shift registers: the next slice is always
    // in the low lane, and read data shifts in from the top so slice 0 ends up lowest.
    generate
        if (D_BEATS > 1) begin : g_rd_multi
            assign rd_next = {bus.bus_data_i, rd_sh[DATA_W-1:LANE_W]};
        end else begin : g_rd_single
            assign rd_next = bus.bus_data_i;
        end
    endgenerate

    always_comb begin
        cmd_word    = '0;
        cmd_word[0] = we_q;
        cmd_word[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            beat            <= '0;
            we_q            <= 1'b0;
            addr_sh         <= '0;
            wdata_sh        <= '0;
            rd_sh           <= '0;
            bus.cpu_ack     <= 1'b0;
            bus.cpu_rdata   <= '0;
            bus.busy        <= 1'b0;
            bus.bus_addr_o  <= '0;
            bus.bus_data_o  <= '0;
            bus.bus_data_oe <= '0;
            bus.bus_frame   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        state          <= ADDR;
                        beat           <= '0;
                        we_q           <= bus.cpu_we;
                        addr_sh        <= bus.cpu_addr >> LANE_W;
                        wdata_sh       <= bus.cpu_wdata;
                        bus.bus_addr_o <= bus.cpu_addr[LANE_W-1:0];
                        bus.bus_frame  <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
                end
                ADDR: begin
                    if (advance) begin
                        if (beat == A_LAST) begin
                            state          <= CMD;
                            beat           <= '0;
                            bus.bus_addr_o <= cmd_word;
                        end else begin
                            beat           <= beat + 1'b1;
                            bus.bus_addr_o <= addr_sh[LANE_W-1:0];
                            addr_sh        <= addr_sh >> LANE_W;
                        end
                    end
                end
                CMD: begin
                    if (advance) begin
                        state          <= DATA;
                        beat           <= '0;
                        bus.bus_addr_o <= '0;
                        if (we_q) begin
                            bus.bus_data_o  <= wdata_sh[LANE_W-1:0];
                            bus.bus_data_oe <= '1;
                            wdata_sh        <= wdata_sh >> LANE_W;
                        end
                    end
                end
                DATA: begin
                    if (advance) begin
                        if (!we_q) begin
                            rd_sh <= rd_next;
                        end
                        if (beat == D_LAST) begin
                            state           <= DONE;
                            beat            <= '0;
                            bus.bus_frame   <= 1'b0;
                            bus.bus_data_o  <= '0;
                            bus.bus_data_oe <= '0;
                            bus.cpu_ack     <= 1'b1;
                            if (!we_q) begin
                                bus.cpu_rdata <= rd_next;
                            end
                        end else begin
                            beat <= beat + 1'b1;
                            if (we_q) begin
                                bus.bus_data_o <= wdata_sh[LANE_W-1:0];
                                wdata_sh       <= wdata_sh >> LANE_W;
                            end
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.cpu_ack <= 1'b0;
                    bus.busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
